// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : apb_pkg
// Brief    : Shared widths and FSM state encoding for the APB master.
// Revision : 1.0 - initial release
// ============================================================================
package apb_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_SETUP  = 2'd1;
  localparam logic [1:0] c_ACCESS = 2'd2;

endpackage : apb_pkg
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`default_nettype none
// ============================================================================
// Module   : apb_wait_timer
// Brief    : Counts ACCESS wait cycles and flags the last one before timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
  parameter int TIMEOUT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam logic [7:0] c_LAST = 8'(TIMEOUT - 1);

  logic [7:0] r_count;

  // The count stops at c_LAST, so it never wraps even if enable stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= 8'd0;
    end else if (i_clear) begin
      r_count <= 8'd0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + 8'd1;
    end
  end

  assign o_expired = (r_count == c_LAST);

endmodule : apb_wait_timer
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module   : apb_master
// Brief    : Single-outstanding APB master with wait-state timeout.
// Revision : 1.0 - initial release
// ============================================================================
module apb_master
  import apb_pkg::*;
#(
  parameter int TIMEOUT = 8
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_pwrite;
  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              w_accept;
  logic              w_done;
  logic              w_timeout;
  logic              w_expired;
  logic              w_tmr_clear;
  logic              w_tmr_enable;

  // Reset is combined in so a command presented during reset is never taken.
  assign cmd_ready = (r_state == c_IDLE) && !PRESETn;
  assign w_accept  = cmd_valid && cmd_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      c_IDLE:   if (w_accept) w_state_nxt = c_SETUP;
      c_SETUP:  w_state_nxt = c_ACCESS;
      c_ACCESS: begin
        if (PREADY) begin
          w_state_nxt = c_IDLE;
          w_done      = 1'b1;
        end else if (w_expired) begin
          w_state_nxt = c_IDLE;
          w_timeout   = 1'b1;
        end
      end
      default:  w_state_nxt = c_IDLE;
    endcase
  end

  assign w_tmr_clear  = (r_state == c_SETUP);
  assign w_tmr_enable = (r_state == c_ACCESS) && !PREADY;

  apb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk       (PCLK),
    .rst       (PRESETn),
    .i_clear   (w_tmr_clear),
    .i_enable  (w_tmr_enable),
    .o_expired (w_expired)
  );

  always_ff @(posedge PCLK) begin
    if (PRESETn) begin
      r_state     <= c_IDLE;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pwrite    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rsp_valid <= w_done || w_timeout;
      if (w_accept) begin
        r_paddr  <= cmd_addr;
        r_pwrite <= cmd_write;
        r_pwdata <= cmd_write ? cmd_wdata : '0;
      end
      // Response fields hold between completions.
      if (w_done) begin
        r_rsp_err   <= 1'b0;
        r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
      end else if (w_timeout) begin
        r_rsp_err   <= 1'b1;
        r_rsp_rdata <= '0;
      end
    end
  end

  assign PSEL      = (r_state == c_SETUP) || (r_state == c_ACCESS);
  assign PENABLE   = (r_state == c_ACCESS);
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule : apb_master
`default_nettype wire

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter: TIMEOUT, 8, number of ACCESS cycles with PREADY low before the transfer is aborted (legal 1..255).
REQ-002 PCLK  input  1  bus clock; all state changes on rising edge.
REQ-003 PRESETn  input  1  synchronous reset, active-high; sampled on PCLK rising edge.
REQ-004 cmd_valid  input  1  command request from local requester.
REQ-005 cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready at a rising edge.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_addr  input  8  target address.
REQ-008 cmd_wdata  input  8  write data; ignored for reads.
REQ-009 rsp_valid  output  1  one-cycle pulse on transfer completion; no backpressure.
REQ-010 rsp_rdata  output  8  read data, valid with rsp_valid; 0 for writes and errors.
REQ-011 rsp_err  output  1  1 with rsp_valid when the transfer timed out.
REQ-012 PSEL, PENABLE, PWRITE  output  1 each  APB control to the slave.
REQ-013 PADDR, PWDATA  output  8 each  APB address and write data.
REQ-014 PRDATA  input  8  APB read data from the slave.
REQ-015 PREADY  input  1  APB transfer-complete from the slave.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-017 IDLE: PSEL=0, PENABLE=0, cmd_ready=1; on accept, latch cmd_write/addr/wdata, go to SETUP.
REQ-018 SETUP: PSEL=1, PENABLE=0, lasts exactly one cycle, then ACCESS unconditionally.
REQ-019 ACCESS: PSEL=1, PENABLE=1; wait counter cleared on entry.
REQ-020 ACCESS with PREADY=1: capture PRDATA (reads only) into rsp_rdata, go to IDLE, rsp_valid=1 in the following cycle.
REQ-021 ACCESS with PREADY=0: if wait count = TIMEOUT-1 go to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0 next cycle; else increment the count.
REQ-022 Latency: command accepted at edge k -> SETUP cycle k+1, first ACCESS cycle k+2, rsp_valid in cycle k+3 when PREADY=1 in the first ACCESS cycle.
REQ-023 PADDR, PWRITE, PWDATA SHALL be stable from SETUP through the last ACCESS cycle; PWDATA=0 for reads; all three retain their last values in IDLE.
REQ-024 cmd_ready SHALL be 0 in SETUP and ACCESS; cmd_valid there is ignored and not queued.
REQ-025 Back-to-back: a command accepted in the cycle rsp_valid is high SHALL start SETUP next cycle (minimum 3 cycles per transfer).
REQ-026 rsp_err=0 and rsp_rdata unchanged-to-0 rules: rsp_rdata and rsp_err are registered and held until the next rsp_valid.
REQ-027 The counter SHALL saturate-free count 0..TIMEOUT-1 in 8 bits; no wrap is possible.

Reset
REQ-028 PRESETn=1 at an edge SHALL force IDLE, PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, rsp_valid=0, rsp_err=0, rsp_rdata=0, wait count 0.
REQ-029 Reset mid-transfer SHALL abort silently: no rsp_valid is issued for the aborted transfer.
REQ-030 Reset and cmd_valid in the same cycle: reset wins; the command is not accepted.
REQ-031 cmd_ready SHALL be 0 while PRESETn=1 and 1 in the first cycle after reset release.

Structure
REQ-032 Shared package apb_pkg SHALL hold ADDR_W=8, DATA_W=8 and the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2).
REQ-033 One sub-module apb_wait_timer (clear, enable, TIMEOUT compare, expired flag) SHALL implement the wait counter; FSM and datapath stay in apb_master.

Verification
REQ-034 Write: cmd addr=0x0F wdata=0xA5, PREADY=1 first ACCESS -> PSEL at k+1, PENABLE at k+2, PWDATA=0xA5, rsp_valid k+3, rsp_err=0.
REQ-035 Read with 2 wait states: addr=0x03, PREADY low 2 cycles then high with PRDATA=0x3C -> rsp_rdata=0x3C at k+5.
REQ-036 Timeout TIMEOUT=4, PREADY held 0 -> ACCESS cycles k+2..k+5, rsp_valid=1 rsp_err=1 rsp_rdata=0 at k+6, PSEL=0 at k+6.
REQ-037 Back-to-back write 0x11 then read: second SETUP in the cycle after first rsp_valid; PADDR/PWDATA never change inside a transfer.
REQ-038 Reset asserted in ACCESS -> PSEL=PENABLE=0 next cycle, no rsp_valid, cmd_ready=1 first cycle after release.
REQ-039 cmd_valid held high during SETUP/ACCESS -> only one transfer per IDLE accept; no spurious second SETUP.
